vram_arbiter: RTL and testbench

//  Shares the single SDRAM MEM_CONTROLLER port between three users: VDP slot accesses, SDRAM refresh and an auxiliary

---
 rtl/vram_arb_pkg.sv | 26 ++
 rtl/vram_refresh_timer.sv | 60 ++++++
 rtl/vram_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: FSM states, grant
// sources and the MEM_CONTROLLER write-size encoding.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_START,
        ARB_WAIT_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VDP,
        GNT_REF,
        GNT_AUX
    } grant_t;

    localparam logic [1:0] WR_SIZE_8  = 2'b00;
    localparam logic [1:0] WR_SIZE_16 = 2'b01;
    localparam logic [1:0] WR_SIZE_32 = 2'b10;

    // Cycles to wait for mem_busy to rise before assuming the op already finished.
    localparam int START_TIMEOUT = 2;

endpackage

// File: rtl/vram_refresh_timer.sv
// Refresh scheduler: an interval counter raises refresh_due every
// REFRESH_INT+1 cycles; a second counter measures how long a due refresh
// has been waiting so the arbiter can force it past the VDP.
module vram_refresh_timer #(
    parameter int REFRESH_INT   = 810,
    parameter int REFRESH_FORCE = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic due,
    output logic force_now
);

    localparam int CNT_W   = $clog2(REFRESH_INT + 1);
    localparam int FORCE_W = $clog2(REFRESH_FORCE + 1);
    localparam logic [CNT_W-1:0]   RELOAD    = CNT_W'(REFRESH_INT);
    localparam logic [FORCE_W-1:0] FORCE_MAX = FORCE_W'(REFRESH_FORCE);

    logic [CNT_W-1:0]   interval_cnt;
    logic [FORCE_W-1:0] force_cnt;
    logic               expire;

    assign expire    = (interval_cnt == '0);
    assign force_now = (force_cnt >= FORCE_MAX);

    // Free-running down counter that reloads on expiry, independent of arbiter activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            interval_cnt <= RELOAD;
        end else if (expire) begin
            interval_cnt <= RELOAD;
        end else begin
            interval_cnt <= interval_cnt - 1'b1;
        end
    end

    // Due flag: a new expiry beats a same-cycle clear so no refresh interval is ever lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            due <= 1'b0;
        end else if (expire) begin
            due <= 1'b1;
        end else if (clear) begin
            due <= 1'b0;
        end
    end

    // Waiting-time counter, only runs while a refresh is due and saturates at the force threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            force_cnt <= '0;
        end else if (clear || !due) begin
            force_cnt <= '0;
        end else if (force_cnt != FORCE_MAX) begin
            force_cnt <= force_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares the single MEM_CONTROLLER port between VDP slot
// accesses (strict priority, captured into a 1-deep pending slot),
// scheduled SDRAM refresh and an auxiliary req/ack requester.
// Every granted op runs IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> IDLE.
module vram_arbiter #(
    parameter int ADDR_W        = 23,
    parameter int REFRESH_INT   = 810,
    parameter int REFRESH_FORCE = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vdp_read,
    input  logic              vdp_write,
    input  logic              vdp_refresh_slot,
    input  logic [ADDR_W-1:0] vdp_addr,
    input  logic [31:0]       vdp_din,
    input  logic [1:0]        vdp_wr_size,
    output logic [31:0]       vdp_dout,
    output logic              vdp_valid,
    output logic              vdp_overrun,
    input  logic              aux_req,
    input  logic              aux_wr,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [31:0]       aux_din,
    input  logic [1:0]        aux_wr_size,
    output logic              aux_ack,
    output logic [31:0]       aux_dout,
    output logic              aux_valid,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [1:0]        mem_wr_size,
    input  logic              mem_busy,
    input  logic [31:0]       mem_dout
);

    import vram_arb_pkg::*;

    arb_state_t state, state_next;
    grant_t     grant, grant_next;

    logic              vdp_strobe;
    logic              pend_valid;
    logic              pend_write;
    logic [ADDR_W-1:0] pend_addr;
    logic [31:0]       pend_din;
    logic [1:0]        pend_size;
    logic              pend_free;

    logic              op_write;
    logic [1:0]        start_wait;
    logic              issuing;
    logic              launch;
    logic              complete;

    logic              refresh_due;
    logic              refresh_force;
    logic              ref_ok;
    logic              aux_ok;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_din;
    logic [1:0]        sel_size;

    assign vdp_strobe = vdp_read | vdp_write;

    // A VDP strobe landing this cycle blocks refresh and aux so the VDP is never
    // overtaken between capture and grant; aux may always use a guaranteed idle window.
    assign ref_ok = refresh_due && (vdp_refresh_slot || refresh_force) && !vdp_strobe;
    assign aux_ok = aux_req && (vdp_refresh_slot || (!pend_valid && !vdp_strobe));

    assign issuing     = (state == ARB_ISSUE);
    assign mem_read    = issuing && ((grant == GNT_VDP) || (grant == GNT_AUX)) && !op_write;
    assign mem_write   = issuing && ((grant == GNT_VDP) || (grant == GNT_AUX)) && op_write;
    assign mem_refresh = issuing && (grant == GNT_REF);
    assign aux_ack     = issuing && (grant == GNT_AUX);
    assign pend_free   = issuing && (grant == GNT_VDP);

    vram_refresh_timer #(
        .REFRESH_INT   (REFRESH_INT),
        .REFRESH_FORCE (REFRESH_FORCE)
    ) u_refresh_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (mem_refresh),
        .due       (refresh_due),
        .force_now (refresh_force)
    );

    // Next-state and grant selection; grants are only made while the controller is idle.
    always_comb begin
        state_next = state;
        grant_next = grant;
        launch     = 1'b0;
        complete   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!mem_busy) begin
                    if (pend_valid) begin
                        grant_next = GNT_VDP;
                        state_next = ARB_ISSUE;
                        launch     = 1'b1;
                    end else if (ref_ok) begin
                        grant_next = GNT_REF;
                        state_next = ARB_ISSUE;
                        launch     = 1'b1;
                    end else if (aux_ok) begin
                        grant_next = GNT_AUX;
                        state_next = ARB_ISSUE;
                        launch     = 1'b1;
                    end
                end
            end
            ARB_ISSUE: begin
                state_next = ARB_WAIT_START;
            end
            ARB_WAIT_START: begin
                if (mem_busy) begin
                    state_next = ARB_WAIT_DONE;
                end else if (start_wait == 2'(START_TIMEOUT - 1)) begin
                    state_next = ARB_IDLE;
                    grant_next = GNT_NONE;
                    complete   = 1'b1;
                end
            end
            ARB_WAIT_DONE: begin
                if (!mem_busy) begin
                    state_next = ARB_IDLE;
                    grant_next = GNT_NONE;
                    complete   = 1'b1;
                end
            end
            default: begin
                state_next = ARB_IDLE;
                grant_next = GNT_NONE;
            end
        endcase
    end

    // Operand mux: picks address/data/size from the source being granted this cycle.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = mem_addr;
        sel_din   = mem_din;
        sel_size  = mem_wr_size;
        if (grant_next == GNT_VDP) begin
            sel_write = pend_write;
            sel_addr  = pend_addr;
            sel_din   = pend_din;
            sel_size  = pend_size;
        end else if (grant_next == GNT_AUX) begin
            sel_write = aux_wr;
            sel_addr  = aux_addr;
            sel_din   = aux_din;
            sel_size  = aux_wr_size;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Granted op: operands are latched at grant and held until the op completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant       <= GNT_NONE;
            op_write    <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_wr_size <= WR_SIZE_8;
        end else begin
            grant <= grant_next;
            if (launch) begin
                op_write    <= sel_write;
                mem_addr    <= sel_addr;
                mem_din     <= sel_din;
                mem_wr_size <= sel_size;
            end
        end
    end

    // Counts cycles spent waiting for mem_busy to rise after a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_wait <= '0;
        end else if (state == ARB_WAIT_START) begin
            start_wait <= start_wait + 1'b1;
        end else begin
            start_wait <= '0;
        end
    end

    // VDP pending slot: the slot frees during ISSUE, so a strobe in that same cycle still lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_addr  <= '0;
            pend_din   <= '0;
            pend_size  <= WR_SIZE_8;
        end else if (vdp_strobe && (!pend_valid || pend_free)) begin
            pend_valid <= 1'b1;
            pend_write <= vdp_write;
            pend_addr  <= vdp_addr;
            pend_din   <= vdp_din;
            pend_size  <= vdp_wr_size;
        end else if (pend_free) begin
            pend_valid <= 1'b0;
        end
    end

    // Sticky overrun: a strobe that finds the slot occupied is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            vdp_overrun <= 1'b0;
        end else if (vdp_strobe && pend_valid && !pend_free) begin
            vdp_overrun <= 1'b1;
        end
    end

    // Read return: captures mem_dout on completion and pulses the owner's valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vdp_valid <= 1'b0;
            vdp_dout  <= '0;
            aux_valid <= 1'b0;
            aux_dout  <= '0;
        end else begin
            vdp_valid <= complete && (grant == GNT_VDP) && !op_write;
            aux_valid <= complete && (grant == GNT_AUX) && !op_write;
            if (complete && (grant == GNT_VDP) && !op_write) begin
                vdp_dout <= mem_dout;
            end
            if (complete && (grant == GNT_AUX) && !op_write) begin
                aux_dout <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: behavioural MEM_CONTROLLER model, a
// scoreboard of expected memory ops and read data, a vector table of
// VDP/aux transactions and hand-written refresh/overrun/reset sequences.
module tb_vram_arbiter;

    localparam int ADDR_W = 23;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              vdp_read = 1'b0, vdp_write = 1'b0, vdp_refresh_slot = 1'b1;
    logic [ADDR_W-1:0] vdp_addr = '0;
    logic [31:0]       vdp_din = '0;
    logic [1:0]        vdp_wr_size = '0;
    logic [31:0]       vdp_dout;
    logic              vdp_valid, vdp_overrun;
    logic              aux_req = 1'b0, aux_wr = 1'b0;
    logic [ADDR_W-1:0] aux_addr = '0;
    logic [31:0]       aux_din = '0;
    logic [1:0]        aux_wr_size = '0;
    logic              aux_ack, aux_valid;
    logic [31:0]       aux_dout;
    logic              mem_read, mem_write, mem_refresh;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [1:0]        mem_wr_size;
    logic              mem_busy;
    logic [31:0]       mem_dout = '0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(ADDR_W), .REFRESH_INT(810), .REFRESH_FORCE(64)) dut (
        .clk(clk), .reset(reset),
        .vdp_read(vdp_read), .vdp_write(vdp_write), .vdp_refresh_slot(vdp_refresh_slot),
        .vdp_addr(vdp_addr), .vdp_din(vdp_din), .vdp_wr_size(vdp_wr_size),
        .vdp_dout(vdp_dout), .vdp_valid(vdp_valid), .vdp_overrun(vdp_overrun),
        .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_din(aux_din),
        .aux_wr_size(aux_wr_size), .aux_ack(aux_ack), .aux_dout(aux_dout), .aux_valid(aux_valid),
        .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr_size(mem_wr_size),
        .mem_busy(mem_busy), .mem_dout(mem_dout)
    );

    typedef struct {
        bit          is_aux;
        bit          wr;
        logic [22:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [22:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
    } mem_op_t;

    mem_op_t     op_q[$];
    logic [31:0] vdp_q[$];
    logic [31:0] aux_q[$];
    mem_op_t     mon_op;
    logic [31:0] mon_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;
    int stim_cyc = 0;
    int last_rw_cyc = -1;
    int ref_count = 0;
    int first_ref_cyc = -1;
    int aux_valid_count = 0;

    // Cycle counter used for latency and refresh-timing checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MEM_CONTROLLER: busy for 3 cycles after any strobe, read data when busy falls.
    logic [31:0] mem_arr [int];
    int          busy_cnt = 0;
    logic        model_busy = 1'b0;
    logic        busy_hold = 1'b0;
    logic [31:0] rd_next = '0;
    assign mem_busy = model_busy | busy_hold;

    function automatic logic [31:0] mem_peek(input logic [22:0] a);
        if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
        return 32'h5A5A_0000 ^ {9'd0, a};
    endfunction

    always @(negedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) begin
                model_busy = 1'b0;
                mem_dout = rd_next;
            end
        end
        if (mem_read || mem_write || mem_refresh) begin
            busy_cnt = 3;
            model_busy = 1'b1;
            if (mem_read) rd_next = mem_peek(mem_addr);
            if (mem_write) mem_arr[int'(mem_addr)] = mem_din;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: pops expected ops/data as the DUT produces them.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_read || mem_write) begin
                last_rw_cyc = cyc;
                if (op_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_mem_op actual addr=0x%06h wr=%0b expected none", mem_addr, mem_write);
                end else begin
                    mon_op = op_q.pop_front();
                    checkOutput("mem_dir_write", 32'(mem_write), 32'(mon_op.wr));
                    checkOutput("mem_addr", 32'(mem_addr), 32'(mon_op.addr));
                    if (mon_op.wr) begin
                        checkOutput("mem_din", mem_din, mon_op.din);
                        checkOutput("mem_wr_size", 32'(mem_wr_size), 32'(mon_op.size));
                    end
                end
            end
            if (mem_refresh) begin
                if (ref_count == 0) first_ref_cyc = cyc;
                ref_count++;
            end
            if (vdp_valid) begin
                if (vdp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_vdp_valid actual dout=0x%08h expected none", vdp_dout);
                end else begin
                    mon_data = vdp_q.pop_front();
                    checkOutput("vdp_dout", vdp_dout, mon_data);
                end
            end
            if (aux_valid) begin
                aux_valid_count++;
                if (aux_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_aux_valid actual dout=0x%08h expected none", aux_dout);
                end else begin
                    mon_data = aux_q.pop_front();
                    checkOutput("aux_dout", aux_dout, mon_data);
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        checkOutput({tag, "_mem_refresh"}, 32'(mem_refresh), 32'd0);
        checkOutput({tag, "_aux_ack"}, 32'(aux_ack), 32'd0);
        checkOutput({tag, "_vdp_valid"}, 32'(vdp_valid), 32'd0);
        checkOutput({tag, "_aux_valid"}, 32'(aux_valid), 32'd0);
        checkOutput({tag, "_vdp_overrun"}, 32'(vdp_overrun), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_din"}, mem_din, 32'd0);
        checkOutput({tag, "_mem_wr_size"}, 32'(mem_wr_size), 32'd0);
        checkOutput({tag, "_vdp_dout"}, vdp_dout, 32'd0);
        checkOutput({tag, "_aux_dout"}, aux_dout, 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        op_q.delete();
        vdp_q.delete();
        aux_q.delete();
        reset = 1'b0;
        rel = cyc;
        ref_count = 0;
        first_ref_cyc = -1;
    endtask

    task automatic waitAck(output int ack_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!aux_ack && n < 100);
        ack_cyc = cyc;
        if (!aux_ack) begin
            checks++;
            errors++;
            $display("[TB] FAIL aux_ack_timeout actual=none expected ack within 100 cycles");
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((op_q.size() != 0 || vdp_q.size() != 0 || aux_q.size() != 0 || mem_busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("[TB] FAIL idle_timeout actual=%0d ops pending expected 0", op_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        int ack_cyc;
        op_q.push_back('{v.wr, v.addr, v.data, v.size});
        if (!v.wr) begin
            if (v.is_aux) aux_q.push_back(v.exp_rdata);
            else vdp_q.push_back(v.exp_rdata);
        end
        stim_cyc = cyc;
        if (v.is_aux) begin
            aux_req = 1'b1;
            aux_wr = v.wr;
            aux_addr = v.addr;
            aux_din = v.data;
            aux_wr_size = v.size;
            waitAck(ack_cyc);
            aux_req = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            vdp_read = !v.wr;
            vdp_write = v.wr;
            vdp_addr = v.addr;
            vdp_din = v.data;
            vdp_wr_size = v.size;
            @(posedge clk);
            #1;
            vdp_read = 1'b0;
            vdp_write = 1'b0;
        end
        waitIdle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=still running expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t tbl[9];
    int   ack_c;
    int   rw_before;
    int   auxv_before;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 23'h000010, 32'h1122_3344, 2'b10, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 23'h7FFFFF, 32'hCAFE_F00D, 2'b10, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 23'h000010, 32'h0,         2'b00, 32'h1122_3344};
        tbl[3] = '{1'b1, 1'b0, 23'h7FFFFF, 32'h0,         2'b00, 32'hCAFE_F00D};
        tbl[4] = '{1'b0, 1'b1, 23'h400000, 32'h0000_BEEF, 2'b01, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 23'h400000, 32'h0,         2'b00, 32'h0000_BEEF};
        tbl[6] = '{1'b1, 1'b1, 23'h000000, 32'h0000_00AB, 2'b00, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 23'h000000, 32'h0,         2'b00, 32'h0000_00AB};
        tbl[8] = '{1'b0, 1'b0, 23'h000200, 32'h0,         2'b00, 32'h5A5A_0200};

        // Reset state.
        vdp_refresh_slot = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        doReset();

        // Idle with the refresh window open: first refresh exactly at cycle 812.
        repeat (830) @(posedge clk);
        #1;
        checkOutput("refresh_first_cycle", 32'(first_ref_cyc - rel), 32'd812);
        checkOutput("refresh_count", 32'(ref_count), 32'd1);

        // VDP read latency and data return.
        mem_arr[int'(23'h000123)] = 32'hDEAD_BEEF;
        applyStimulus('{1'b0, 1'b0, 23'h000123, 32'h0, 2'b00, 32'hDEAD_BEEF});
        checkOutput("vdp_read_latency", 32'(last_rw_cyc - stim_cyc), 32'd2);

        // Vector table.
        for (int i = 0; i < 9; i++) applyStimulus(tbl[i]);

        // Aux write and VDP write in the same cycle: VDP goes first, aux acks after it completes.
        doReset();
        vdp_refresh_slot = 1'b0;
        op_q.push_back('{1'b1, 23'h000ABC, 32'h1234_5678, 2'b10});
        op_q.push_back('{1'b1, 23'h07FFFF, 32'h0000_55AA, 2'b01});
        aux_req = 1'b1;
        aux_wr = 1'b1;
        aux_addr = 23'h07FFFF;
        aux_din = 32'h0000_55AA;
        aux_wr_size = 2'b01;
        vdp_write = 1'b1;
        vdp_addr = 23'h000ABC;
        vdp_din = 32'h1234_5678;
        vdp_wr_size = 2'b10;
        stim_cyc = cyc;
        @(posedge clk);
        #1;
        vdp_write = 1'b0;
        waitAck(ack_c);
        aux_req = 1'b0;
        checkOutput("aux_ack_after_vdp", 32'(ack_c - stim_cyc), 32'd7);
        @(posedge clk);
        #1;
        waitIdle();

        // Two VDP writes while the controller stays busy: second dropped, overrun sticky.
        checkOutput("overrun_before", 32'(vdp_overrun), 32'd0);
        busy_hold = 1'b1;
        rw_before = last_rw_cyc;
        op_q.push_back('{1'b1, 23'h001000, 32'h0000_0001, 2'b10});
        vdp_write = 1'b1;
        vdp_addr = 23'h001000;
        vdp_din = 32'h0000_0001;
        vdp_wr_size = 2'b10;
        @(posedge clk);
        #1;
        vdp_write = 1'b0;
        @(posedge clk);
        #1;
        vdp_write = 1'b1;
        vdp_addr = 23'h002000;
        vdp_din = 32'h0000_0002;
        @(posedge clk);
        #1;
        vdp_write = 1'b0;
        checkOutput("overrun_set", 32'(vdp_overrun), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("held_while_busy", 32'(last_rw_cyc - rw_before), 32'd0);
        busy_hold = 1'b0;
        waitIdle();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("overrun_sticky", 32'(vdp_overrun), 32'd1);

        // Reset during WAIT_DONE of an aux read: no aux_valid, everything cleared.
        vdp_refresh_slot = 1'b1;
        auxv_before = aux_valid_count;
        op_q.push_back('{1'b0, 23'h000321, 32'h0, 2'b00});
        aux_req = 1'b1;
        aux_wr = 1'b0;
        aux_addr = 23'h000321;
        waitAck(ack_c);
        aux_req = 1'b0;
        busy_hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("midop_reset");
        busy_hold = 1'b0;
        doReset();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("no_aux_valid_after_reset", 32'(aux_valid_count - auxv_before), 32'd0);

        // Refresh due with the window closed: forced once force_cnt reaches 64.
        vdp_refresh_slot = 1'b0;
        doReset();
        repeat (900) @(posedge clk);
        #1;
        checkOutput("forced_refresh_cycle", 32'(first_ref_cyc - rel), 32'd876);
        checkOutput("forced_refresh_count", 32'(ref_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
